// File: rtl/fp_pkg.sv
// Shared floating-point types, constants and helpers.
// Used by the multiplier and its operand classifier.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ROUND,
    DONE
  } mul_state_e;

  // bit positions inside the 4-bit flags vector
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // canonical quiet NaN, right-aligned in 64 bits
  function automatic logic [63:0] fp_qnan(
    input int ew,
    input int mw
  );
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ew; i++)
      v[mw+i] = 1'b1;
    v[mw-1] = 1'b1;
    return v;
  endfunction

  // signed infinity, right-aligned in 64 bits
  function automatic logic [63:0] fp_inf(
    input logic s,
    input int   ew,
    input int   mw
  );
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ew; i++)
      v[mw+i] = 1'b1;
    v[ew+mw] = s;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Unpacks one operand into sign/exp/frac and class.
// Ports: x in; sign, exp, frac (FTZ applied), cls out.
module fp_classify
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FW    = EXP_W + MAN_W + 1
) (
  input  logic [FW-1:0]    x,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] frac,
  output fp_class_e        cls
);

  logic e_ones;
  logic e_zero;
  logic f_nz;

  assign e_ones = &x[FW-2:MAN_W];
  assign e_zero = ~|x[FW-2:MAN_W];
  assign f_nz   = |x[MAN_W-1:0];

  always_comb begin
    sign = x[FW-1];
    exp  = x[FW-2:MAN_W];
    frac = x[MAN_W-1:0];
    cls  = NORM;
    unique case (1'b1)
      e_ones && f_nz:  cls = NAN;
      e_ones && !f_nz: cls = INF;
      // subnormals flush to zero, sign kept
      e_zero: begin
        cls  = ZERO;
        frac = '0;
      end
      default: cls = NORM;
    endcase
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP multiplier, shift-add mantissa, RNE.
// Ports: clk, reset, in_valid/in_ready, a, b,
//        out_valid/out_ready, result, flags.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FW    = EXP_W + MAN_W + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] result,
  output logic [3:0]    flags
);

  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * SW;
  localparam int EW2 = EXP_W + 2;
  localparam int CW  = $clog2(SW);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW2-1:0] BIAS_S =
    BIAS[EW2-1:0];
  localparam logic signed [EW2-1:0] EMAX_S =
    EMAX[EW2-1:0];
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  localparam logic [CW-1:0] CNT_LAST = CW'(MAN_W);

  localparam logic [63:0] QNAN64 =
    fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0] INF64 =
    fp_inf(1'b0, EXP_W, MAN_W);

  localparam logic [FW-1:0] QNAN    = QNAN64[FW-1:0];
  localparam logic [FW-2:0] INF_MAG = INF64[FW-2:0];

  mul_state_e state;

  logic                  sgn;
  logic signed [EW2-1:0] e;
  logic [PW-1:0]         mcand;
  logic [SW-1:0]         mplier;
  logic [PW-1:0]         acc;
  logic [CW-1:0]         cnt;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;

  fp_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_cls_a (
    .x   (a),
    .sign(sa),
    .exp (ea),
    .frac(fa),
    .cls (ca)
  );

  fp_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_cls_b (
    .x   (b),
    .sign(sb),
    .exp (eb),
    .frac(fb),
    .cls (cb)
  );

  // accept-time decode
  logic                  s_in;
  logic                  special;
  logic [FW-1:0]         sp_res;
  logic [3:0]            sp_flags;
  logic signed [EW2-1:0] e_in;

  always_comb begin
    s_in     = sa ^ sb;
    special  = (ca != NORM) || (cb != NORM);
    sp_res   = '0;
    sp_flags = '0;
    e_in = $signed({2'b00, ea})
         + $signed({2'b00, eb})
         - BIAS_S;
    if (ca == NAN || cb == NAN) begin
      sp_res = QNAN;
    end else if ((ca == INF && cb == ZERO) ||
                 (ca == ZERO && cb == INF)) begin
      sp_res = QNAN;
      sp_flags[FLAG_INVALID] = 1'b1;
    end else if (ca == INF || cb == INF) begin
      sp_res = {s_in, INF_MAG};
    end else begin
      sp_res = {s_in, {(FW-1){1'b0}}};
    end
  end

  // normalise / round / range check of the product
  logic [PW-1:0]         norm;
  logic [SW-1:0]         sig;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [SW:0]           sig_r;
  logic signed [EW2-1:0] e_r;
  logic [FW-1:0]         rd_res;
  logic [3:0]            rd_flags;
  logic                  rd_unused;

  always_comb begin
    norm   = acc[PW-1] ? acc : (acc << 1);
    sig    = norm[PW-1 -: SW];
    guard  = norm[SW-1];
    sticky = |norm[SW-2:0];
    inc    = guard & (sticky | sig[0]);
    sig_r  = {1'b0, sig} + {{SW{1'b0}}, inc};
    // carry-out leaves sig_r = 10...0, frac bits 0
    e_r = e
        + {{(EW2-1){1'b0}}, acc[PW-1]}
        + {{(EW2-1){1'b0}}, sig_r[SW]};
    rd_flags = '0;
    rd_flags[FLAG_INEXACT] = guard | sticky;
    if (e_r >= EMAX_S) begin
      rd_res = {sgn, INF_MAG};
      rd_flags[FLAG_OVERFLOW] = 1'b1;
      rd_flags[FLAG_INEXACT]  = 1'b1;
    end else if (e_r <= E_ZERO) begin
      rd_res = {sgn, {(FW-1){1'b0}}};
      rd_flags[FLAG_UNDERFLOW] = 1'b1;
      rd_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      rd_res = {sgn, e_r[EXP_W-1:0],
                sig_r[MAN_W-1:0]};
    end
  end

  // hidden bit of the rounded significand
  assign rd_unused = sig_r[MAN_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      sgn       <= 1'b0;
      e         <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sgn      <= s_in;
            in_ready <= 1'b0;
            if (special) begin
              result    <= sp_res;
              flags     <= sp_flags;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              e      <= e_in;
              mcand  <= {{SW{1'b0}}, 1'b1, fa};
              mplier <= {1'b1, fb};
              acc    <= '0;
              cnt    <= '0;
              state  <= MULT;
            end
          end
        end
        MULT: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= ROUND;
        end
        ROUND: begin
          result    <= rd_res;
          flags     <= rd_flags;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq, binary32 and binary16.
// Directed table, handshake/reset sequences, random vs model.
module tb_fp_mul_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int          sel;
  logic        iv;
  logic        ordy;
  logic [63:0] av;
  logic [63:0] bv;

  logic        ir32, ov32;
  logic [31:0] r32;
  logic [3:0]  f32;
  logic        ir16, ov16;
  logic [15:0] r16;
  logic [3:0]  f16;

  fp_mul_seq dut32 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv && sel == 0),
    .in_ready (ir32),
    .a        (av[31:0]),
    .b        (bv[31:0]),
    .out_valid(ov32),
    .out_ready(ordy),
    .result   (r32),
    .flags    (f32)
  );

  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv && sel == 1),
    .in_ready (ir16),
    .a        (av[15:0]),
    .b        (bv[15:0]),
    .out_valid(ov16),
    .out_ready(ordy),
    .result   (r16),
    .flags    (f16)
  );

  logic        ir, ov;
  logic [63:0] res;
  logic [3:0]  flg;

  always_comb begin
    ir  = (sel == 1) ? ir16 : ir32;
    ov  = (sel == 1) ? ov16 : ov32;
    res = (sel == 1) ? {48'd0, r16} : {32'd0, r32};
    flg = (sel == 1) ? f16 : f32;
  end

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference: exact integer product, then RNE by remainder.
  function automatic void model(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  int          ew,
    input  int          mw,
    output logic [63:0] r,
    output logic [3:0]  f,
    output int          lat
  );
    longint unsigned emax, one, fa, fb, ea, eb;
    longint unsigned p, q, rem, half, s;
    longint          e;
    int              ka, kb, sh;
    emax = (64'd1 << ew) - 1;
    one  = 64'd1 << mw;
    s    = 64'(a[ew+mw] ^ b[ew+mw]);
    ea   = (a >> mw) & emax;
    eb   = (b >> mw) & emax;
    fa   = a & (one - 1);
    fb   = b & (one - 1);
    ka = (ea == 0) ? 0 : (ea != emax) ? 1 :
         (fa == 0) ? 2 : 3;
    kb = (eb == 0) ? 0 : (eb != emax) ? 1 :
         (fb == 0) ? 2 : 3;
    f   = 4'b0000;
    lat = 1;
    if (ka == 3 || kb == 3) begin
      r = (emax << mw) | (one >> 1);
    end else if ((ka == 2 && kb == 0) ||
                 (ka == 0 && kb == 2)) begin
      r = (emax << mw) | (one >> 1);
      f = 4'b1000;
    end else if (ka == 2 || kb == 2) begin
      r = (s << (ew + mw)) | (emax << mw);
    end else if (ka == 0 || kb == 0) begin
      r = s << (ew + mw);
    end else begin
      lat = mw + 3;
      p = (one + fa) * (one + fb);
      e = longint'(ea) + longint'(eb)
        - ((longint'(1) << (ew - 1)) - 1);
      sh = mw;
      if (p >= (64'd1 << (2 * mw + 1))) begin
        sh = mw + 1;
        e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem != 0) f[0] = 1'b1;
      if (rem > half || (rem == half && q[0]))
        q++;
      if (q == 2 * one) begin
        q = one;
        e++;
      end
      if (e >= longint'(emax)) begin
        r = (s << (ew + mw)) | (emax << mw);
        f = 4'b0101;
      end else if (e <= 0) begin
        r = s << (ew + mw);
        f = 4'b0011;
      end else begin
        r = (s << (ew + mw))
          | (longint'(e) << mw) | (q - one);
      end
    end
  endfunction

  function automatic logic [63:0] gen(input int ew,
                                      input int mw);
    longint unsigned emax, e, f, s;
    int bias, k;
    emax = (64'd1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    k    = $urandom_range(0, 15);
    f    = {$urandom, $urandom};
    f    = f & ((64'd1 << mw) - 1);
    s    = 64'($urandom_range(0, 1));
    case (k)
      0:       e = 0;
      1:       e = emax;
      2: begin e = emax; f = 0; end
      3:       e = 1;
      4:       e = emax - 1;
      default: e = 64'($urandom_range(bias / 2,
                                      bias + bias / 2));
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  task automatic run(input int s,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic [63:0] xr,
                     input logic [3:0]  xf,
                     input int          xlat,
                     input string       nm);
    int lat;
    int w;
    sel = s;
    #1;
    w = 0;
    while (!ir && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({nm, " in_ready"}, 64'(ir), 64'd1);
    @(negedge clk);
    av   = a;
    bv   = b;
    iv   = 1'b1;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    iv  = 1'b0;
    lat = 1;
    while (!ov && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " out_valid"}, 64'(ov), 64'd1);
    chk({nm, " result"}, res, xr);
    chk({nm, " flags"}, 64'(flg), 64'(xf));
    chk({nm, " latency"}, 64'(lat), 64'(xlat));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [3:0]  f;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [63:0] xr, ra, rb;
    logic [3:0]  xf;
    int          xl;

    tbl.push_back('{0, 64'h411C0000, 64'h3F100000,
                    64'h40AF8000, 4'b0000, 26, "exact"});
    tbl.push_back('{0, 64'h3F800001, 64'h3F800001,
                    64'h3F800002, 4'b0001, 26, "inexact"});
    tbl.push_back('{0, 64'h7F800000, 64'h80000000,
                    64'h7FC00000, 4'b1000, 1, "inf_x_zero"});
    tbl.push_back('{0, 64'h7F000000, 64'h40000000,
                    64'h7F800000, 4'b0101, 26, "overflow"});
    tbl.push_back('{0, 64'h00800000, 64'h00800000,
                    64'h00000000, 4'b0011, 26, "underflow"});
    tbl.push_back('{0, 64'h00000101, 64'h40000000,
                    64'h00000000, 4'b0000, 1, "ftz"});
    tbl.push_back('{0, 64'h7F812345, 64'h3F800000,
                    64'h7FC00000, 4'b0000, 1, "nan_in"});
    tbl.push_back('{0, 64'hFF800000, 64'h40000000,
                    64'hFF800000, 4'b0000, 1, "inf_x_norm"});
    tbl.push_back('{1, 64'h3C01, 64'h3C01,
                    64'h3C02, 4'b0001, 13, "h_inexact"});
    tbl.push_back('{1, 64'h7C00, 64'h0000,
                    64'h7E00, 4'b1000, 1, "h_inf_x_zero"});

    sel   = 0;
    iv    = 1'b0;
    ordy  = 1'b1;
    av    = '0;
    bv    = '0;
    reset = 1'b1;
    #12;
    chk("rst in_ready32", 64'(ir32), 64'd1);
    chk("rst out_valid32", 64'(ov32), 64'd0);
    chk("rst result32", 64'(r32), 64'd0);
    chk("rst flags32", 64'(f32), 64'd0);
    chk("rst in_ready16", 64'(ir16), 64'd1);
    chk("rst out_valid16", 64'(ov16), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      run(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].r,
          tbl[i].f, tbl[i].lat, tbl[i].nm);

    // backpressure in DONE
    sel = 0;
    @(negedge clk);
    av   = 64'h411C0000;
    bv   = 64'h3F100000;
    iv   = 1'b1;
    ordy = 1'b0;
    @(posedge clk);
    #1;
    iv = 1'b0;
    for (int k = 0; k < 40 && !ov32; k++) begin
      @(posedge clk);
      #1;
    end
    chk("bp out_valid", 64'(ov32), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      iv = 1'b1;
      av = 64'($urandom);
      bv = 64'($urandom);
      @(posedge clk);
      #1;
      chk("bp result hold", 64'(r32), 64'h40AF8000);
      chk("bp flags hold", 64'(f32), 64'd0);
      chk("bp in_ready low", 64'(ir32), 64'd0);
      chk("bp out_valid hold", 64'(ov32), 64'd1);
    end
    @(negedge clk);
    iv   = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp transfer ov", 64'(ov32), 64'd0);
    chk("bp transfer ir", 64'(ir32), 64'd1);
    @(posedge clk);
    #1;
    chk("bp single xfer", 64'(ov32), 64'd0);

    // reset in the middle of MULT, both widths
    for (int s = 0; s < 2; s++) begin
      sel = s;
      @(negedge clk);
      av = (s == 0) ? 64'h40400000 : 64'h4200;
      bv = av;
      iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("mid ir before", 64'(ir), 64'd0);
      reset = 1'b1;
      #1;
      chk("mid rst out_valid", 64'(ov), 64'd0);
      chk("mid rst in_ready", 64'(ir), 64'd1);
      chk("mid rst result", res, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      if (s == 0)
        run(0, 64'h40000000, 64'h41100000,
            64'h41900000, 4'b0000, 26, "after_rst32");
      else
        run(1, 64'h4000, 64'h4880,
            64'h4C80, 4'b0000, 13, "after_rst16");
    end

    // random against reference model
    for (int n = 0; n < 100; n++) begin
      int s;
      int ew;
      int mw;
      s  = (n < 60) ? 0 : 1;
      ew = (s == 0) ? 8 : 5;
      mw = (s == 0) ? 23 : 10;
      ra = gen(ew, mw);
      rb = gen(ew, mw);
      model(ra, rb, ew, mw, xr, xf, xl);
      run(s, ra, rb, xr, xf, xl,
          $sformatf("rand%0d %h*%h", n, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
